bus_dma: RTL

BUS_DMA -- requirements
Module: bus_dma

---
 rtl/bus_dma.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_dma.sv
// Single-channel word-copy DMA: register slave on the device port, copy engine on the host port.
// Build option BUS_DMA_IRQ_EN adds STATUS.irq_en and a level interrupt dma_irq_o = done & irq_en.
module bus_dma #(
   parameter int LenWidth = 16
) (
   input  logic        clk_sys_i,
   input  logic        rst_sys_ni,
   input  logic        device_req_i,
   input  logic [31:0] device_addr_i,
   input  logic        device_we_i,
   input  logic [3:0]  device_be_i,
   input  logic [31:0] device_wdata_i,
   output logic        device_rvalid_o,
   output logic [31:0] device_rdata_o,
   output logic        device_err_o,
   output logic        host_req_o,
   output logic [31:0] host_addr_o,
   output logic        host_we_o,
   output logic [3:0]  host_be_o,
   output logic [31:0] host_wdata_o,
   input  logic        host_gnt_i,
   input  logic        host_rvalid_i,
   input  logic [31:0] host_rdata_i,
   input  logic        host_err_i,
   output logic        dma_irq_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT
   } state_e;

   localparam logic [2:0] OffSrc    = 3'd0;
   localparam logic [2:0] OffDst    = 3'd1;
   localparam logic [2:0] OffLen    = 3'd2;
   localparam logic [2:0] OffCtrl   = 3'd3;
   localparam logic [2:0] OffStatus = 3'd4;

   state_e              r_state, w_state_nxt;
   logic [31:0]         r_src, r_dst, r_wsrc, r_wdst, r_buf, r_rdata;
   logic [LenWidth-1:0] r_len, r_wlen;
   logic                r_busy, r_done, r_err, r_rvalid, r_derr, r_irq;
   logic [2:0]          w_off;
   logic                w_mapped, w_wr, w_wr_st, w_start, w_launch, w_zero;
   logic                w_rd_done, w_wr_done, w_abort, w_last;
   logic                w_done_nxt, w_err_nxt, w_irq_en, w_irq_d;
   logic [31:0]         w_rdata;
   logic                w_unused;

   function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wdata,
                                            input logic [3:0] be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
      return res;
   endfunction

   assign w_unused  = ^{device_addr_i[31:5], device_addr_i[1:0]};
   assign w_off     = device_addr_i[4:2];
   assign w_mapped  = (w_off <= OffStatus);
   assign w_wr      = device_req_i & device_we_i & w_mapped;
   assign w_wr_st   = w_wr & (w_off == OffStatus) & device_be_i[0];
   assign w_start   = w_wr & (w_off == OffCtrl) & device_be_i[0] & device_wdata_i[0] & ~r_busy;
   assign w_launch  = w_start & (r_len != '0);
   assign w_zero    = w_start & (r_len == '0);

   // Responses arriving outside a WAIT state (e.g. just after reset) are dropped here.
   assign w_abort   = host_rvalid_i & host_err_i & ((r_state == S_RD_WAIT) | (r_state == S_WR_WAIT));
   assign w_rd_done = host_rvalid_i & ~host_err_i & (r_state == S_RD_WAIT);
   assign w_wr_done = host_rvalid_i & ~host_err_i & (r_state == S_WR_WAIT);
   assign w_last    = w_wr_done & (r_wlen == LenWidth'(1));

   // NOTE: async active-low reset sits in the sensitivity list; state uses non-blocking <= only.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) r_state <= S_IDLE;
      else             r_state <= w_state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:    if (w_launch) w_state_nxt = S_RD_REQ;
         S_RD_REQ:  if (host_gnt_i) w_state_nxt = S_RD_WAIT;
         S_RD_WAIT: begin
            if (w_abort)        w_state_nxt = S_IDLE;
            else if (w_rd_done) w_state_nxt = S_WR_REQ;
         end
         S_WR_REQ:  if (host_gnt_i) w_state_nxt = S_WR_WAIT;
         S_WR_WAIT: begin
            if (w_abort || w_last) w_state_nxt = S_IDLE;
            else if (w_wr_done)    w_state_nxt = S_RD_REQ;
         end
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      host_req_o   = 1'b0;
      host_addr_o  = '0;
      host_we_o    = 1'b0;
      host_be_o    = '0;
      host_wdata_o = '0;
      if (r_state == S_RD_REQ) begin
         host_req_o  = 1'b1;
         host_addr_o = r_wsrc;
         host_be_o   = 4'hF;
      end else if (r_state == S_WR_REQ) begin
         host_req_o   = 1'b1;
         host_addr_o  = r_wdst;
         host_we_o    = 1'b1;
         host_be_o    = 4'hF;
         host_wdata_o = r_buf;
      end
   end

   // Set events are applied after the W1C clears so they win in a shared cycle.
   always_comb begin
      w_done_nxt = r_done;
      w_err_nxt  = r_err;
      if (w_wr_st && device_wdata_i[1]) w_done_nxt = 1'b0;
      if (w_wr_st && device_wdata_i[2]) w_err_nxt  = 1'b0;
      if (w_launch || w_zero) begin
         w_done_nxt = 1'b0;
         w_err_nxt  = 1'b0;
      end
      if (w_zero || w_last || w_abort) w_done_nxt = 1'b1;
      if (w_abort)                     w_err_nxt  = 1'b1;
   end

`ifdef BUS_DMA_IRQ_EN
   logic r_irq_en;
   logic w_irq_en_nxt;
   assign w_irq_en_nxt = w_wr_st ? device_wdata_i[3] : r_irq_en;
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) r_irq_en <= 1'b0;
      else             r_irq_en <= w_irq_en_nxt;
   end
   assign w_irq_en = r_irq_en;
   assign w_irq_d  = w_done_nxt & w_irq_en_nxt;
`else
   assign w_irq_en = 1'b0;
   assign w_irq_d  = 1'b0;
`endif

   always_comb begin
      w_rdata = '0;
      case (w_off)
         OffSrc:    w_rdata = r_src;
         OffDst:    w_rdata = r_dst;
         OffLen:    w_rdata = 32'(r_len);
         OffStatus: w_rdata = {28'd0, w_irq_en, r_err, r_done, r_busy};
         default:   w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         r_src    <= '0;
         r_dst    <= '0;
         r_len    <= '0;
         r_wsrc   <= '0;
         r_wdst   <= '0;
         r_wlen   <= '0;
         r_buf    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_derr   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_rvalid <= device_req_i;
         r_derr   <= device_req_i & ~w_mapped;
         r_rdata  <= (device_req_i && !device_we_i) ? w_rdata : '0;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         r_irq    <= w_irq_d;
         if (w_wr && !r_busy) begin
            case (w_off)
               OffSrc:  r_src <= merge_be(r_src, device_wdata_i, device_be_i) & ~32'h3;
               OffDst:  r_dst <= merge_be(r_dst, device_wdata_i, device_be_i) & ~32'h3;
               OffLen:  r_len <= LenWidth'(merge_be(32'(r_len), device_wdata_i, device_be_i));
               default: ;
            endcase
         end
         if (w_launch) begin
            r_busy <= 1'b1;
            r_wsrc <= r_src;
            r_wdst <= r_dst;
            r_wlen <= r_len;
         end
         if (w_rd_done) r_buf <= host_rdata_i;
         if (w_wr_done) begin
            r_wsrc <= r_wsrc + 32'd4;
            r_wdst <= r_wdst + 32'd4;
            r_wlen <= r_wlen - LenWidth'(1);
         end
         if (w_abort || w_last) r_busy <= 1'b0;
      end
   end

   assign device_rvalid_o = r_rvalid;
   assign device_rdata_o  = r_rdata;
   assign device_err_o    = r_derr;
   assign dma_irq_o       = r_irq;

endmodule
